// File: rtl/hub75_pkg.sv
// Shared HUB75 panel geometry, RGB444 pixel layout and scanner state encoding.
package hub75_pkg;

    localparam int unsigned COLS      = 32;
    localparam int unsigned HALF_ROWS = 16;
    localparam int unsigned PLANES    = 4;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned PIX_W     = 12;
    localparam int unsigned COL_W     = 5;
    localparam int unsigned ROW_W     = 4;
    localparam int unsigned PLANE_W   = 2;

    // Pixel field offsets, also used by the DMA's 12-bit unpack.
    localparam int unsigned R_LSB = 8;
    localparam int unsigned G_LSB = 4;
    localparam int unsigned B_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_TOP,
        ST_FETCH_BOT,
        ST_SETUP,
        ST_CLOCK,
        ST_LATCH,
        ST_DISPLAY
    } scan_state_e;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_bits_t;

    // Selects one BCM plane's R/G/B bits from an RGB444 pixel.
    function automatic rgb_bits_t plane_bits(input logic [PIX_W-1:0] pix,
                                             input logic [PLANE_W-1:0] plane);
        logic [PIX_W-1:0] s;
        rgb_bits_t        b;
        s   = pix >> plane;
        b.r = s[R_LSB];
        b.g = s[G_LSB];
        b.b = s[B_LSB];
        return b;
    endfunction

endpackage

// File: rtl/hub75_bcm_scanner_timer.sv
// BCM on-time timer: lights the panel for BASE_ON<<plane cycles after each latch.
module bcm_on_timer
    import hub75_pkg::*;
#(
    parameter int unsigned BASE_ON = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [PLANE_W-1:0] plane_i,
    output logic               done_o,
    output logic               oe_n_o
);

    localparam int unsigned CNT_W = $clog2((BASE_ON << (PLANES - 1)) + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] load_val;
    logic             active_q;
    logic             done_q;
    logic             oe_n_q;

    assign load_val = CNT_W'((BASE_ON << plane_i) - 1);

    // Countdown of the lit period; done marks the final lit cycle, oe_n tracks activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            oe_n_q   <= 1'b1;
        end else if (start_i) begin
            cnt_q    <= load_val;
            active_q <= 1'b1;
            done_q   <= (load_val == '0);
            oe_n_q   <= 1'b0;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_q <= 1'b0;
                done_q   <= 1'b0;
                oe_n_q   <= 1'b1;
            end else begin
                cnt_q  <= cnt_q - CNT_W'(1);
                done_q <= (cnt_q == CNT_W'(1));
            end
        end
    end

    assign done_o = done_q;
    assign oe_n_o = oe_n_q;

endmodule

// File: rtl/hub75_bcm_scanner.sv
// HUB75 32x32 1/16-scan driver with 4-plane binary code modulation.
module hub75_bcm_scanner
    import hub75_pkg::*;
#(
    parameter int unsigned BASE_ON = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              r1,
    output logic              g1,
    output logic              b1,
    output logic              r2,
    output logic              g2,
    output logic              b2,
    output logic              pix_clk,
    output logic              lat,
    output logic              oe_n,
    output logic [ROW_W-1:0]  row_addr,
    output logic              frame_start
);

    scan_state_e        state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [PLANE_W-1:0] plane_q, plane_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [PIX_W-1:0]   top_q;
    rgb_bits_t          top_bits_q, bot_bits_q;
    logic               pix_clk_q, lat_q, frame_start_q, frame_start_d;
    logic [ROW_W-1:0]   row_addr_q;
    logic               timer_start;
    logic               on_done;

    // State and scan counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            plane_q <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            plane_q <= plane_d;
            row_q   <= row_d;
        end
    end

    // Next-state: 4-cycle column shift, latch, lit period, then next plane/row/frame.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        plane_d       = plane_q;
        row_d         = row_q;
        timer_start   = 1'b0;
        frame_start_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d       = ST_FETCH_TOP;
                    col_d         = '0;
                    plane_d       = '0;
                    row_d         = '0;
                    frame_start_d = 1'b1;
                end
            end
            ST_FETCH_TOP: state_d = ST_FETCH_BOT;
            ST_FETCH_BOT: state_d = ST_SETUP;
            ST_SETUP:     state_d = ST_CLOCK;
            ST_CLOCK: begin
                if (col_q == COL_W'(COLS - 1)) begin
                    col_d   = '0;
                    state_d = ST_LATCH;
                end else begin
                    col_d   = col_q + COL_W'(1);
                    state_d = ST_FETCH_TOP;
                end
            end
            ST_LATCH: begin
                timer_start = 1'b1;
                state_d     = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                if (on_done) begin
                    if (plane_q != PLANE_W'(PLANES - 1)) begin
                        plane_d = plane_q + PLANE_W'(1);
                        state_d = ST_FETCH_TOP;
                    end else begin
                        plane_d = '0;
                        if (row_q != ROW_W'(HALF_ROWS - 1)) begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = ST_FETCH_TOP;
                        end else begin
                            row_d = '0;
                            if (enable) begin
                                state_d       = ST_FETCH_TOP;
                                frame_start_d = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame buffer address: top half, then bottom half (bit 9 set), else 0.
    always_comb begin
        rd_addr = '0;
        if (state_q == ST_FETCH_TOP) begin
            rd_addr = {1'b0, row_q, col_q};
        end else if (state_q == ST_FETCH_BOT) begin
            rd_addr = {1'b1, row_q, col_q};
        end
    end

    // Registered panel outputs; each reflects the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_q         <= '0;
            top_bits_q    <= '0;
            bot_bits_q    <= '0;
            pix_clk_q     <= 1'b0;
            lat_q         <= 1'b0;
            row_addr_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            if (state_q == ST_FETCH_BOT) begin
                top_q <= rd_data;
            end
            if (state_q == ST_SETUP) begin
                top_bits_q <= plane_bits(top_q, plane_q);
                bot_bits_q <= plane_bits(rd_data, plane_q);
            end
            if (state_d == ST_LATCH) begin
                row_addr_q <= row_q;
            end
            pix_clk_q     <= (state_d == ST_CLOCK);
            lat_q         <= (state_d == ST_LATCH);
            frame_start_q <= frame_start_d;
        end
    end

    bcm_on_timer #(
        .BASE_ON (BASE_ON)
    ) u_on_timer (
        .clk     (clk),
        .rst     (rst),
        .start_i (timer_start),
        .plane_i (plane_q),
        .done_o  (on_done),
        .oe_n_o  (oe_n)
    );

    assign {r1, g1, b1} = top_bits_q;
    assign {r2, g2, b2} = bot_bits_q;
    assign pix_clk      = pix_clk_q;
    assign lat          = lat_q;
    assign row_addr     = row_addr_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Self-checking bench: per-cycle comparison against a frame-schedule reference model.
module tb_hub75_bcm_scanner;

    localparam int BASE_ON   = 4;
    localparam int ROW_CYC   = 576;
    localparam int FRAME_CYC = 9216;

    typedef struct packed {
        logic       pix_clk;
        logic       lat;
        logic       oe_n;
        logic       rgb_valid;
        logic [9:0] rd_addr;
        logic [3:0] row_addr;
        logic [5:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [9:0]  rd_addr;
    logic [11:0] rd_data;
    logic        r1, g1, b1, r2, g2, b2;
    logic        pix_clk, lat, oe_n, frame_start;
    logic [3:0]  row_addr;
    logic [11:0] mem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Synchronous-read frame buffer with one cycle of latency.
    always @(posedge clk) rd_data <= mem[rd_addr];

    hub75_bcm_scanner #(
        .BASE_ON (BASE_ON)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .r1          (r1),
        .g1          (g1),
        .b1          (b1),
        .r2          (r2),
        .g2          (g2),
        .b2          (b2),
        .pix_clk     (pix_clk),
        .lat         (lat),
        .oe_n        (oe_n),
        .row_addr    (row_addr),
        .frame_start (frame_start)
    );

    // Expected panel signals at cycle t of a frame, from the frame timing arithmetic.
    function automatic exp_t model(input int t, input int prev_ra);
        exp_t        e;
        int          row, u, p, s, v, col, ph;
        logic [11:0] top, bot;
        e      = '0;
        e.oe_n = 1'b1;
        row    = t / ROW_CYC;
        u      = t % ROW_CYC;
        p      = 0;
        s      = 0;
        while (u >= s + 129 + (BASE_ON << p)) begin
            s += 129 + (BASE_ON << p);
            p++;
        end
        v = u - s;
        if (p > 0 || v >= 128) e.row_addr = 4'(row);
        else if (row == 0)     e.row_addr = 4'(prev_ra);
        else                   e.row_addr = 4'(row - 1);
        if (v < 128) begin
            col = v / 4;
            ph  = v % 4;
            if (ph == 0) e.rd_addr = 10'(row * 32 + col);
            if (ph == 1) e.rd_addr = 10'((row + 16) * 32 + col);
            if (ph == 3) begin
                top         = mem[row * 32 + col];
                bot         = mem[(row + 16) * 32 + col];
                e.pix_clk   = 1'b1;
                e.rgb_valid = 1'b1;
                e.rgb       = {top[8 + p], top[4 + p], top[p], bot[8 + p], bot[4 + p], bot[p]};
            end
        end else if (v == 128) begin
            e.lat = 1'b1;
        end else begin
            e.oe_n = 1'b0;
        end
        return e;
    endfunction

    // Runs one frame from its frame_start cycle, checking every cycle.
    task automatic run_frame(input int prev_ra, input int drop_row, input logic expect_next,
                             input string tag);
        exp_t       e;
        logic [3:0] last_ra;
        logic       last_pc;
        int         rises, lats;
        last_ra = row_addr;
        last_pc = pix_clk;
        rises   = 0;
        lats    = 0;
        for (int t = 0; t < FRAME_CYC; t++) begin
            if (t == drop_row * ROW_CYC) enable = 1'b0;
            e = model(t, prev_ra);
            n_checks += 6;
            if (frame_start !== (t == 0)) begin
                n_fail++;
                $display("FAIL %s frame_start t=%0d got %b exp %b", tag, t, frame_start, (t == 0));
            end
            if (pix_clk !== e.pix_clk) begin
                n_fail++;
                $display("FAIL %s pix_clk t=%0d got %b exp %b", tag, t, pix_clk, e.pix_clk);
            end
            if (lat !== e.lat) begin
                n_fail++;
                $display("FAIL %s lat t=%0d got %b exp %b", tag, t, lat, e.lat);
            end
            if (oe_n !== e.oe_n) begin
                n_fail++;
                $display("FAIL %s oe_n t=%0d got %b exp %b", tag, t, oe_n, e.oe_n);
            end
            if (rd_addr !== e.rd_addr) begin
                n_fail++;
                $display("FAIL %s rd_addr t=%0d got %0d exp %0d", tag, t, rd_addr, e.rd_addr);
            end
            if (row_addr !== e.row_addr) begin
                n_fail++;
                $display("FAIL %s row_addr t=%0d got %0d exp %0d", tag, t, row_addr, e.row_addr);
            end
            if (e.rgb_valid) begin
                n_checks++;
                if ({r1, g1, b1, r2, g2, b2} !== e.rgb) begin
                    n_fail++;
                    $display("FAIL %s rgb t=%0d got %b exp %b", tag, t, {r1, g1, b1, r2, g2, b2}, e.rgb);
                end
            end
            if (t == 3 * ROW_CYC + 20 || t == 3 * ROW_CYC + 21) begin
                n_checks++;
                if (rd_addr !== ((t == 3 * ROW_CYC + 20) ? 10'd101 : 10'd613)) begin
                    n_fail++;
                    $display("FAIL %s addr_trace t=%0d got %0d", tag, t, rd_addr);
                end
            end
            n_checks += 2;
            if (lat === 1'b1 && oe_n === 1'b0) begin
                n_fail++;
                $display("FAIL %s lat_during_display t=%0d got lat=%b oe_n=%b", tag, t, lat, oe_n);
            end
            if (row_addr !== last_ra && lat !== 1'b1) begin
                n_fail++;
                $display("FAIL %s row_addr_unblanked t=%0d got %0d exp %0d", tag, t, row_addr, last_ra);
            end
            if (pix_clk === 1'b1 && last_pc === 1'b0) rises++;
            if (lat === 1'b1) lats++;
            last_pc = pix_clk;
            last_ra = row_addr;
            @(negedge clk);
        end
        n_checks += 3;
        if (frame_start !== expect_next) begin
            n_fail++;
            $display("FAIL %s next_frame_start got %b exp %b", tag, frame_start, expect_next);
        end
        if (rises != 2048) begin
            n_fail++;
            $display("FAIL %s pix_clk_rises got %0d exp 2048", tag, rises);
        end
        if (lats != 64) begin
            n_fail++;
            $display("FAIL %s lat_pulses got %0d exp 64", tag, lats);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 3;
        if ({r1, g1, b1, r2, g2, b2, pix_clk, lat, oe_n, frame_start} !== 10'b0000000010) begin
            n_fail++;
            $display("FAIL reset_outputs got %b exp %b",
                     {r1, g1, b1, r2, g2, b2, pix_clk, lat, oe_n, frame_start}, 10'b0000000010);
        end
        if (row_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_row_addr got %0d exp 0", row_addr);
        end
        if (rd_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_rd_addr got %0d exp 0", rd_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_buffer();
        for (int i = 0; i < 1024; i++) mem[i] = 12'h000;
        n_checks += 2;
        if (frame_start !== 1'b0 || oe_n !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_before_enable got frame_start=%b oe_n=%b exp 0 1", frame_start, oe_n);
        end
        enable = 1'b1;
        @(negedge clk);
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL first_frame_start got %b exp 1", frame_start);
        end
        run_frame(0, -1, 1'b1, "zero");
    endtask

    task automatic test_corner_pixels();
        for (int i = 0; i < 1024; i++) mem[i] = 12'h000;
        mem[0]   = 12'hF00;
        mem[512] = 12'h00F;
        run_frame(15, -1, 1'b1, "corner");
    endtask

    task automatic test_random_enable_drop();
        for (int i = 0; i < 1024; i++) mem[i] = 12'($urandom);
        run_frame(15, 7, 1'b0, "random_drop");
    endtask

    task automatic test_idle_after_drop();
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (frame_start !== 1'b0 || oe_n !== 1'b1 || pix_clk !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_drop cycle=%0d got fs=%b oe_n=%b pc=%b exp 0 1 0",
                         i, frame_start, oe_n, pix_clk);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_display();
        bit found;
        enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_frame_start got %b exp 1", frame_start);
        end
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (oe_n === 1'b0 && row_addr === 4'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_display got timeout exp oe_n=0 on row 2");
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (oe_n !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_oe_n got %b exp 1", oe_n);
        end
        if (lat !== 1'b0 || pix_clk !== 1'b0 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ctrl got lat=%b pc=%b fs=%b exp 0 0 0", lat, pix_clk, frame_start);
        end
        if (row_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_row_addr got %0d exp 0", row_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL post_rst_frame_start got %b exp 1", frame_start);
        end
        for (int i = 0; i < 1024; i++) mem[i] = 12'($urandom);
        run_frame(0, -1, 1'b1, "restart");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 12'h000;
        test_reset();
        test_zero_buffer();
        test_corner_pixels();
        test_random_enable_drop();
        test_idle_after_drop();
        test_reset_display();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hub75_bcm_scanner.md
Name: hub75_bcm_scanner

Overview:
- Consumes the 1024 x 12-bit RGB444 frame buffer (distributed RAM) that the SDRAM DMA fills.
- Drives a 32x32 HUB75 LED panel: 1/16 scan, two half-panels shifted in parallel.
- Uses 4-plane binary code modulation (BCM) for intensity.
- Owns the RAM read port; the DMA owns the write port.

Parameters:
- COLS, 32, pixels per panel row.
- HALF_ROWS, 16, row pairs (scan lines); row_addr width = 4.
- ADDR_W, 10, frame buffer address width.
- PLANES, 4, bits per colour channel.
- BASE_ON, 4, oe_n-low cycles for plane 0; plane p is lit for BASE_ON<<p cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  run scanning; sampled only at frame boundary
- rd_addr  out  10  frame buffer read address
- rd_data  in  12  frame buffer data; synchronous read, 1-cycle latency; [11:8]=R, [7:4]=G, [3:0]=B
- r1, g1, b1  out  1 each  upper-half colour bits
- r2, g2, b2  out  1 each  lower-half colour bits
- pix_clk  out  1  HUB75 shift clock; panel samples on rising edge
- lat  out  1  HUB75 latch
- oe_n  out  1  HUB75 output enable, active-low
- row_addr  out  4  HUB75 A..D row select
- frame_start  out  1  1-cycle pulse at start of each frame (DMA trigger)

Behaviour:
- Reset values: oe_n=1, lat=0, pix_clk=0, all rgb=0, row_addr=0, rd_addr=0, frame_start=0. Counters col, plane, row = 0; state = IDLE.
- Reset wins over everything. Reset mid-operation forces the reset values on the next clock edge, including oe_n=1.
- States: IDLE, FETCH_TOP, FETCH_BOT, SETUP, CLOCK, LATCH, DISPLAY.
- IDLE:
  - oe_n=1.
  - enable=1 moves to FETCH_TOP with row=plane=col=0 and pulses frame_start during that first FETCH_TOP cycle.
- FETCH_TOP: rd_addr = row*32 + col.
- FETCH_BOT:
  - rd_addr = (row+16)*32 + col.
  - Capture rd_data as top pixel.
- SETUP:
  - Capture rd_data as bottom pixel.
  - Register r1/g1/b1 = top[8+plane]/top[4+plane]/top[plane]; r2/g2/b2 likewise from the bottom pixel.
  - pix_clk=0.
- CLOCK:
  - pix_clk=1, rgb held stable.
  - If col==COLS-1: col=0, go to LATCH. Otherwise col+1, go to FETCH_TOP.
- Column cost: exactly 4 cycles per column, 128 cycles per plane. Exactly COLS rising edges of pix_clk per plane.
- oe_n stays 1 throughout the shift phase (no overlap with display).
- LATCH:
  - Lasts 1 cycle: lat=1, oe_n=1.
  - row_addr is registered from row on this cycle, so it changes only while blanked.
- DISPLAY:
  - oe_n=0 for exactly BASE_ON<<plane cycles, then oe_n=1.
  - If plane<PLANES-1: plane+1, go to FETCH_TOP.
  - Else plane=0; if row<HALF_ROWS-1: row+1, go to FETCH_TOP.
  - Else (frame end) row=0. If enable=1, go to FETCH_TOP and pulse frame_start; otherwise go to IDLE.
- enable deasserted mid-frame has no effect until the frame completes.
- Frame period: 16*(4*129 + BASE_ON*15) cycles; 9216 at defaults.
- rd_addr is combinational from state and counters: 0 outside the FETCH states.
- Arithmetic: row*32 is a shift. The +16 sets address bit 9. No overflow is possible.

Decomposition:
- Shared package hub75_pkg:
  - Constants COLS, HALF_ROWS, PLANES.
  - Pixel field offsets R_LSB=8, G_LSB=4, B_LSB=0.
  - State enum for this FSM.
- Pixel layout constants are shared with the DMA's 12-bit unpack.
- One natural sub-module: bcm_on_timer.
  - Loads BASE_ON<<plane on entry to DISPLAY, counts down, asserts done.
  - Owns oe_n generation.

Test Plan:
- Reset, then enable=1 with an all-zero buffer -> all rgb=0 every cycle; 32 pix_clk rising edges and 1 lat pulse per plane; first frame_start on the cycle after enable is sampled.
- Buffer addr 0=12'hF00, addr 512=12'h00F, rest 0 -> at the first pix_clk rise of every plane in row 0: r1=1, b2=1, others 0; all other columns 0.
- Address trace for row 3, col 5 -> rd_addr 101 in FETCH_TOP, then 613 in FETCH_BOT, on consecutive cycles.
- BASE_ON=4 -> oe_n low exactly 4, 8, 16, 32 cycles for planes 0..3; lat never high while oe_n=0; row_addr changes only on a lat=1 cycle.
- Continuous run -> row_addr sequences 0..15 then wraps to 0; frame_start pulses exactly 9216 cycles apart.
- Deassert enable mid-frame (row 7) -> scanning continues to the end of row 15, then IDLE with oe_n=1 and no further frame_start.
- Assert rst during DISPLAY -> oe_n=1, lat=0, row_addr=0 on the next edge; frame_start pulses again after release with enable=1.
